// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - shared constants for the full-subtractor self-test engine
package fs_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int VEC_W    = 3;
  localparam int NUM_VECS = 8;
  localparam int ERR_W    = 4;

endpackage

// File: rtl/fs_bist_if.sv
// rtl/fs_bist_if.sv - stimulus/response and status bundle between the engine and its surroundings
interface fs_bist_if;
  import fs_pkg::*;

  logic             start;
  logic             a;
  logic             b;
  logic             bin;
  logic             difference;
  logic             borrow;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [VEC_W-1:0] first_fail_vec;

  modport master (
    input  start, difference, borrow,
    output a, b, bin, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

  modport slave (
    output start, difference, borrow,
    input  a, b, bin, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

endinterface

// File: rtl/fs_ref_model.sv
// rtl/fs_ref_model.sv - golden combinational full-subtractor response
module fs_ref_model (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic exp_d,
  output logic exp_b
);

  assign exp_d = a ^ b ^ bin;
  assign exp_b = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/fs_bist.sv
// rtl/fs_bist.sv - walks all eight {a,b,bin} vectors through a full subtractor and scores the responses
module fs_bist
  import fs_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic      clk,
  input  logic      rst,
  fs_bist_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECS - 1);

  logic [1:0]       state;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] drive;
  logic [CNT_W-1:0] cnt;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [VEC_W-1:0] first_fail_vec;
  logic             exp_d;
  logic             exp_b;
  logic             mismatch;
  logic             start_ok;

  fs_ref_model u_ref (
    .a     (vec[2]),
    .b     (vec[1]),
    .bin   (vec[0]),
    .exp_d (exp_d),
    .exp_b (exp_b)
  );

  assign mismatch = (bus.difference != exp_d) || (bus.borrow != exp_b);
  assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  // drive mirrors vec while running and is parked at 0 outside a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      vec            <= '0;
      drive          <= '0;
      cnt            <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            vec            <= '0;
            drive          <= '0;
            cnt            <= CNT_LOAD;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            state          <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
            if (!fail_valid) begin
              first_fail_vec <= vec;
              fail_valid     <= 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            drive <= '0;
            state <= ST_DONE;
          end else begin
            vec   <= vec + VEC_W'(1);
            drive <= vec + VEC_W'(1);
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.a              = drive[2];
  assign bus.b              = drive[1];
  assign bus.bin            = drive[0];
  assign bus.busy           = (state == ST_SETTLE) || (state == ST_CHECK);
  assign bus.done           = (state == ST_DONE);
  assign bus.pass           = (state == ST_DONE) && (err_count == '0);
  assign bus.err_count      = err_count;
  assign bus.fail_valid     = fail_valid;
  assign bus.first_fail_vec = first_fail_vec;

endmodule

// File: doc/fs_bist.md
Name: fs_bist

Overview:
- Synthesizable built-in self-test engine for the full-subtractor cell. It is the response/checking end of the stimulus flow.
- On a start pulse it walks all 8 input vectors {a,b,bin} and drives them into a full-subtractor instance.
- After a settle window it samples difference/borrow and compares them against an internal reference.
- Reports error count, first failing vector and pass/done status. It sits beside the subtractor in board-level self-test wrappers.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- CNT_W, 4, width of the settle down-counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; accepted only in IDLE or DONE.
- a  output  1  minuend bit to DUT.
- b  output  1  subtrahend bit to DUT.
- bin  output  1  borrow-in bit to DUT.
- difference  input  1  DUT difference response.
- borrow  input  1  DUT borrow-out response.
- busy  output  1  high while the sequence runs (SETTLE or CHECK).
- done  output  1  high in DONE state; held until the next accepted start or reset.
- pass  output  1  done and err_count==0.
- err_count  output  4  number of mismatching vectors, 0..8.
- fail_valid  output  1  at least one mismatch recorded this run.
- first_fail_vec  output  3  {a,b,bin} of the first mismatch; 0 when fail_valid is 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, vec=0, cnt=0. All outputs 0: a, b, bin, busy, done, pass, err_count, fail_valid, first_fail_vec.
- a, b, bin are registered and equal vec[2], vec[1], vec[0] while busy. They are forced to 0 in IDLE and DONE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1: vec<=0, cnt<=SETTLE_CYCLES-1, err_count<=0, fail_valid<=0, first_fail_vec<=0, go to SETTLE.
- SETTLE: if cnt==0 go to CHECK, else cnt<=cnt-1. Each vector is therefore held SETTLE_CYCLES cycles in SETTLE, plus 1 cycle in CHECK.
- CHECK:
  - Compare difference against exp_d = a^b^bin, and borrow against exp_b = (~a&b) | (~(a^b)&bin).
  - On any mismatch: err_count<=err_count+1. If fail_valid==0, first_fail_vec<=vec and fail_valid<=1.
  - If vec==7, go to DONE. Otherwise vec<=vec+1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- DONE: done=1, pass=(err_count==0). start=1 restarts exactly as from IDLE: counters are cleared and done drops next cycle.
- start while busy is ignored; no restart, no effect on counters.
- Latency: start sampled at edge 0 → done high after edge 8*(SETTLE_CYCLES+1). With the default this is 24 cycles.
- vec never wraps mid-run; increment happens only when vec<7. err_count saturates naturally at 8 and cannot exceed it.
- Reset asserted mid-run aborts immediately to reset values. No partial results are retained.
- Inputs difference/borrow are sampled only in CHECK; X or glitching in other states is ignored.

Decomposition:
- Package fs_pkg:
  - state encoding constants ST_IDLE=0, ST_SETTLE=1, ST_CHECK=2, ST_DONE=3 (2 bits).
  - VEC_W=3, NUM_VECS=8.
- Sub-module fs_ref_model: combinational (a,b,bin) → (exp_d, exp_b). It is reused by future subtractor/adder checkers.

Test Plan:
- Correct full-subtractor DUT, SETTLE_CYCLES=2, start pulse → busy 1 for 24 cycles, vectors 0..7 driven in order; then done=1, pass=1, err_count=0, fail_valid=0.
- DUT borrow stuck-at-0 → mismatches at vectors 1,2,3,7; done with err_count=4, first_fail_vec=3'b001, pass=0.
- DUT difference inverted → all 8 mismatch; err_count=8, first_fail_vec=3'b000, fail_valid=1.
- Extra start pulses at cycles 5 and 12 while busy → ignored; done still arrives at cycle 24 with unchanged results.
- rst pulsed at cycle 10 mid-run → all outputs 0 immediately, state IDLE; a new start then completes normally with pass=1.
- From DONE with err_count=4, start → next cycle done=0, err_count=0, fail_valid=0, a/b/bin=000. Then rerun with a correct DUT → pass=1; SETTLE_CYCLES=1 variant → done after 16 cycles.
